// File: rtl/axi_mram_dma_master.sv
// axi_mram_dma_master: single-outstanding AXI4 INCR burst initiator between local
// valid/ready streams and the AXI MRAM slave, reporting response, error and stall status.
module axi_mram_dma_master #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 64,
    parameter int TIMEOUT_CYCLE = 10000
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [7:0]            CMD_LEN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  RD_LAST,
    input  logic                  RD_READY,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [7:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic [1:0]            M_AXI_AWBURST,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]            M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RLAST,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    output logic                  DONE,
    output logic [1:0]            RESP,
    output logic [3:0]            ERR_CODE,
    output logic                  STATUS_TIMEOUT
);
    localparam int SH = $clog2(DATA_WIDTH / 8);
    localparam int EW = ADDR_WIDTH + 9;
    localparam int TW = $clog2(TIMEOUT_CYCLE + 1);
    localparam logic [TW-1:0] TO = TW'(TIMEOUT_CYCLE);
    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, FIN} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] addr, aligned;
    logic [7:0] len, beat;
    logic [1:0] resp, in_resp;
    logic [3:0] err_code, err_ev;
    logic [TW-1:0] tcnt;
    logic [EW-1:0] end_addr;
    logic timeout_flag, accept, range_err, w_hs, b_hs, r_hs, stall, last_beat;
    assign aligned   = (CMD_ADDR >> SH) << SH;
    assign end_addr  = EW'(aligned) + ((EW'(CMD_LEN) + EW'(1)) << SH);
    assign range_err = end_addr > (EW'(1) << ADDR_WIDTH);
    assign accept    = CMD_VALID && state == IDLE;
    assign last_beat = beat == len;
    assign w_hs      = state == W && WR_VALID && M_AXI_WREADY;
    assign b_hs      = state == B && M_AXI_BVALID;
    assign r_hs      = state == R && M_AXI_RVALID && RD_READY;
    assign in_resp   = state == B ? M_AXI_BRESP : M_AXI_RRESP;
    assign stall = (state == AW && !M_AXI_AWREADY) || (state == AR && !M_AXI_ARREADY) ||
                   (state == W && WR_VALID && !M_AXI_WREADY) || (state == B && !M_AXI_BVALID) ||
                   (state == R && !M_AXI_RVALID);
    // Candidate error this cycle; only recorded if no earlier error is held.
    assign err_ev = (r_hs && M_AXI_RLAST && !last_beat) ? 4'd2 :
                    (r_hs && !M_AXI_RLAST && last_beat) ? 4'd3 :
                    (tcnt == TO) ? 4'd4 :
                    (state == FIN && resp != 2'b00) ? 4'd5 : 4'd0;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !CMD_VALID ? IDLE : range_err ? FIN : CMD_WRITE ? AW : AR;
            AW:      state_nx = M_AXI_AWREADY ? W : AW;
            W:       state_nx = (w_hs && last_beat) ? B : W;
            B:       state_nx = M_AXI_BVALID ? FIN : B;
            AR:      state_nx = M_AXI_ARREADY ? R : AR;
            R:       state_nx = (r_hs && last_beat) ? FIN : R;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state        <= IDLE;
            addr         <= '0;
            len          <= '0;
            beat         <= '0;
            resp         <= '0;
            err_code     <= '0;
            timeout_flag <= 1'b0;
            tcnt         <= '0;
        end else begin
            state <= state_nx;
            tcnt  <= !stall ? '0 : (tcnt == TO) ? tcnt : tcnt + 1'b1;
            if (accept) begin
                if (!range_err) begin
                    addr <= aligned;
                    len  <= CMD_LEN;
                end
                beat         <= '0;
                resp         <= range_err ? 2'b10 : 2'b00;
                err_code     <= range_err ? 4'd1 : 4'd0;
                timeout_flag <= 1'b0;
            end else begin
                if (w_hs || r_hs) beat <= beat + 1'b1;
                if ((b_hs || r_hs) && in_resp > resp) resp <= in_resp;
                if (err_code == 4'd0) err_code <= err_ev;
                if (tcnt == TO) timeout_flag <= 1'b1;
            end
        end
    end
    assign CMD_READY      = state == IDLE;
    assign M_AXI_AWADDR   = addr;
    assign M_AXI_AWLEN    = len;
    assign M_AXI_AWSIZE   = 3'(SH);
    assign M_AXI_AWBURST  = 2'b01;
    assign M_AXI_AWVALID  = state == AW;
    assign M_AXI_WDATA    = WR_DATA;
    assign M_AXI_WVALID   = state == W && WR_VALID;
    assign M_AXI_WLAST    = state == W && last_beat;
    assign WR_READY       = state == W && M_AXI_WREADY;
    assign M_AXI_BREADY   = state == B;
    assign M_AXI_ARADDR   = addr;
    assign M_AXI_ARLEN    = len;
    assign M_AXI_ARSIZE   = 3'(SH);
    assign M_AXI_ARBURST  = 2'b01;
    assign M_AXI_ARVALID  = state == AR;
    assign RD_DATA        = M_AXI_RDATA;
    assign RD_VALID       = state == R && M_AXI_RVALID;
    assign RD_LAST        = state == R && last_beat;
    assign M_AXI_RREADY   = state == R && RD_READY;
    assign DONE           = state == FIN;
    assign RESP           = resp;
    assign ERR_CODE       = err_code;
    assign STATUS_TIMEOUT = timeout_flag;
endmodule

// File: tb/tb_axi_mram_dma_master.sv
// tb_axi_mram_dma_master: randomized bench with a behavioural AXI slave and a
// word-array reference memory for axi_mram_dma_master.
module tb_axi_mram_dma_master;
    logic        ACLK = 0, ARESETN = 0;
    logic        CMD_VALID = 0, CMD_READY, CMD_WRITE = 0;
    logic [9:0]  CMD_ADDR = '0;
    logic [7:0]  CMD_LEN = '0;
    logic [63:0] WR_DATA = '0, RD_DATA;
    logic        WR_VALID = 0, WR_READY, RD_VALID, RD_LAST, RD_READY = 0;
    logic [9:0]  M_AXI_AWADDR, M_AXI_ARADDR;
    logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN;
    logic [2:0]  M_AXI_AWSIZE, M_AXI_ARSIZE;
    logic [1:0]  M_AXI_AWBURST, M_AXI_ARBURST;
    logic        M_AXI_AWVALID, M_AXI_AWREADY = 0, M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY = 0;
    logic [63:0] M_AXI_WDATA, M_AXI_RDATA = '0;
    logic [1:0]  M_AXI_BRESP = '0, M_AXI_RRESP = '0;
    logic        M_AXI_BVALID = 0, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY = 0;
    logic        M_AXI_RLAST = 0, M_AXI_RVALID = 0, M_AXI_RREADY;
    logic        DONE, STATUS_TIMEOUT;
    logic [1:0]  RESP;
    logic [3:0]  ERR_CODE;

    axi_mram_dma_master dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
        .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_LAST(RD_LAST), .RD_READY(RD_READY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
        .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .DONE(DONE), .RESP(RESP), .ERR_CODE(ERR_CODE), .STATUS_TIMEOUT(STATUS_TIMEOUT)
    );

    always #5 ACLK = ~ACLK;

    int n_tests = 0, n_fail = 0;
    logic [63:0] mem [0:127];
    logic [63:0] ref_mem [0:127];
    logic [63:0] src[$], w_data[$], rd_data[$];
    bit          w_last[$], rd_last[$];
    int          aw_stall_cfg, rd_mode, rlast_mode, early_idx;
    bit          wr_rand, wready_rand, rvalid_rand;
    logic [1:0]  bresp_cfg;
    logic [1:0]  rresp_cfg [0:255];
    logic [9:0]  o_awaddr, o_araddr;
    logic [7:0]  o_awlen, o_arlen;
    logic [2:0]  o_awsize, o_arsize;
    logic [1:0]  o_awburst, o_arburst;
    int          n_aw, n_ar, done_cnt, c_acc, c_last, c_done;
    bit          timed_out, saw_valid, aw_drop, w_early, to_seen;
    logic        p_ready, p_to;
    logic [1:0]  p_resp;
    logic [3:0]  p_err;

    task automatic set_defaults();
        aw_stall_cfg = 0; rd_mode = 0; rlast_mode = 0; early_idx = 0;
        wr_rand = 0; wready_rand = 0; rvalid_rand = 0; bresp_cfg = 2'b00;
        for (int i = 0; i < 256; i++) rresp_cfg[i] = 2'b00;
    endtask

    // Runs one command in lockstep against a behavioural slave, recording what was observed.
    task automatic do_cmd(input bit wr, input logic [9:0] a, input logic [7:0] l, input int budget);
        int cyc = 0, hold = aw_stall_cfg, src_i = 0, wcnt = 0, rbeat = 0, rlen = 0, base = 0;
        bit sent = 0, awg = 0, aw_on = 0, bdue = 0, ract = 0, fin = 0;
        w_data.delete(); w_last.delete(); rd_data.delete(); rd_last.delete();
        n_aw = 0; n_ar = 0; done_cnt = 0; c_acc = -100; c_last = -100; c_done = -200;
        timed_out = 0; saw_valid = 0; aw_drop = 0; w_early = 0; to_seen = 0;
        while (1) begin
            @(negedge ACLK);
            CMD_VALID = !sent; CMD_WRITE = wr; CMD_ADDR = a; CMD_LEN = l;
            WR_VALID = wr && src_i < src.size() && (!wr_rand || $urandom_range(1) == 1);
            WR_DATA = WR_VALID ? src[src_i] : {$urandom, $urandom};
            M_AXI_AWREADY = hold == 0;
            M_AXI_WREADY = !wready_rand || $urandom_range(1) == 1;
            M_AXI_BVALID = bdue; M_AXI_BRESP = bresp_cfg;
            M_AXI_ARREADY = 1;
            M_AXI_RVALID = ract && (!rvalid_rand || $urandom_range(1) == 1);
            M_AXI_RDATA = ract ? mem[(base + rbeat) % 128] : '0;
            M_AXI_RRESP = ract ? rresp_cfg[rbeat] : 2'b00;
            M_AXI_RLAST = ract && (rlast_mode == 0 ? rbeat == rlen :
                                   rlast_mode == 1 ? (rbeat == early_idx || rbeat == rlen) : 1'b0);
            RD_READY = rd_mode == 0 ? 1'b1 : rd_mode == 1 ? (cyc % 2 == 0) : ($urandom_range(1) == 1);
            #1;
            if (fin) begin
                if (DONE) done_cnt++;
                p_ready = CMD_READY; p_resp = RESP; p_err = ERR_CODE; p_to = STATUS_TIMEOUT;
                break;
            end
            if (CMD_VALID && CMD_READY) begin sent = 1; c_acc = cyc; end
            if (STATUS_TIMEOUT) to_seen = 1;
            if (M_AXI_WVALID && !awg) w_early = 1;
            if (aw_on && !awg && !M_AXI_AWVALID) aw_drop = 1;
            if (M_AXI_AWVALID) begin
                saw_valid = 1; aw_on = 1;
                if (M_AXI_AWREADY) begin
                    o_awaddr = M_AXI_AWADDR; o_awlen = M_AXI_AWLEN; o_awsize = M_AXI_AWSIZE;
                    o_awburst = M_AXI_AWBURST; n_aw++; awg = 1; base = int'(M_AXI_AWADDR) / 8;
                end else if (hold > 0) hold--;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin bdue = 0; c_last = cyc; end
            if (WR_VALID && WR_READY) src_i++;
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_data.push_back(M_AXI_WDATA); w_last.push_back(M_AXI_WLAST);
                mem[(base + wcnt) % 128] = M_AXI_WDATA; wcnt++;
                if (M_AXI_WLAST) bdue = 1;
            end
            if (RD_VALID && RD_READY) begin rd_data.push_back(RD_DATA); rd_last.push_back(RD_LAST); end
            if (M_AXI_RVALID && M_AXI_RREADY) begin
                rbeat++;
                if (rbeat > rlen) begin ract = 0; c_last = cyc; end
            end
            if (M_AXI_ARVALID) begin
                saw_valid = 1;
                if (M_AXI_ARREADY) begin
                    o_araddr = M_AXI_ARADDR; o_arlen = M_AXI_ARLEN; o_arsize = M_AXI_ARSIZE;
                    o_arburst = M_AXI_ARBURST; n_ar++; ract = 1; rbeat = 0;
                    rlen = int'(M_AXI_ARLEN); base = int'(M_AXI_ARADDR) / 8;
                end
            end
            if (DONE) begin done_cnt++; c_done = cyc; fin = 1; end
            cyc++;
            if (cyc > budget) begin timed_out = 1; break; end
        end
        CMD_VALID = 0; WR_VALID = 0; M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_RLAST = 0; RD_READY = 0;
    endtask

    task automatic test_reset();
        ARESETN = 0;
        repeat (3) @(negedge ACLK);
        #1;
        n_tests++;
        if ({CMD_READY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, RD_VALID,
             WR_READY, DONE, STATUS_TIMEOUT, RESP, ERR_CODE} !== 16'h8000) begin
            n_fail++; $display("FAIL reset_ctrl: got %h expected 8000", {CMD_READY, M_AXI_AWVALID, M_AXI_WVALID,
                M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, RD_VALID, WR_READY, DONE, STATUS_TIMEOUT, RESP, ERR_CODE});
        end
        n_tests++;
        if ({M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_ARADDR, M_AXI_ARLEN} !== 36'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h expected 0", {M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_ARADDR, M_AXI_ARLEN});
        end
        n_tests++;
        if ({M_AXI_AWSIZE, M_AXI_ARSIZE, M_AXI_AWBURST, M_AXI_ARBURST} !== {3'd3, 3'd3, 2'b01, 2'b01}) begin
            n_fail++; $display("FAIL reset_const: got %h expected %h",
                {M_AXI_AWSIZE, M_AXI_ARSIZE, M_AXI_AWBURST, M_AXI_ARBURST}, {3'd3, 3'd3, 2'b01, 2'b01});
        end
        ARESETN = 1;
        @(negedge ACLK);
        #1;
        n_tests++;
        if ({CMD_READY, DONE, M_AXI_AWVALID, M_AXI_ARVALID} !== 4'b1000) begin
            n_fail++; $display("FAIL post_reset_idle: got %b expected 1000", {CMD_READY, DONE, M_AXI_AWVALID, M_AXI_ARVALID});
        end
    endtask

    task automatic test_write_basic();
        int bad = 0;
        logic [3:0] lp = '0;
        set_defaults();
        src.delete();
        for (int i = 0; i < 4; i++) src.push_back({$urandom, $urandom});
        do_cmd(1, 10'h040, 8'd3, 200);
        n_tests++;
        if (timed_out) begin n_fail++; $display("FAIL wr_basic_budget: got timeout expected DONE"); end
        n_tests++;
        if ({o_awaddr, o_awlen, o_awsize, o_awburst} !== {10'h040, 8'd3, 3'd3, 2'b01} || n_aw != 1 || n_ar != 0) begin
            n_fail++; $display("FAIL wr_basic_aw: got addr %h len %0d size %0d burst %0d aw %0d ar %0d expected 040 3 3 1 1 0",
                o_awaddr, o_awlen, o_awsize, o_awburst, n_aw, n_ar);
        end
        for (int i = 0; i < w_data.size() && i < 4; i++) begin
            lp[i] = w_last[i];
            if (w_data[i] !== src[i]) bad++;
        end
        n_tests++;
        if (w_data.size() != 4 || lp !== 4'b1000 || bad != 0 || w_early) begin
            n_fail++; $display("FAIL wr_basic_beats: got %0d beats last %b bad %0d early %0d expected 4 1000 0 0",
                w_data.size(), lp, bad, w_early);
        end
        n_tests++;
        if (c_done != c_last + 1 || c_done - c_acc != 7 || done_cnt != 1) begin
            n_fail++; $display("FAIL wr_basic_timing: got done-B %0d done-accept %0d pulses %0d expected 1 7 1",
                c_done - c_last, c_done - c_acc, done_cnt);
        end
        n_tests++;
        if ({p_ready, p_resp, p_err} !== 7'b1_00_0000) begin
            n_fail++; $display("FAIL wr_basic_status: got ready %b resp %b err %0d expected 1 00 0", p_ready, p_resp, p_err);
        end
        for (int i = 0; i < 4; i++) ref_mem[8 + i] = src[i];
    endtask

    task automatic test_read_toggle();
        int bad = 0, lbad = 0;
        set_defaults();
        rd_mode = 1;
        do_cmd(0, 10'h100, 8'd7, 200);
        n_tests++;
        if (timed_out || {o_araddr, o_arlen, o_arsize, o_arburst} !== {10'h100, 8'd7, 3'd3, 2'b01} || n_aw != 0) begin
            n_fail++; $display("FAIL rd_toggle_ar: got to %0d addr %h len %0d size %0d burst %0d aw %0d expected 0 100 7 3 1 0",
                timed_out, o_araddr, o_arlen, o_arsize, o_arburst, n_aw);
        end
        for (int i = 0; i < rd_data.size(); i++) begin
            if (i < 8 && rd_data[i] !== ref_mem[32 + i]) bad++;
            if (rd_last[i] != (i == 7)) lbad++;
        end
        n_tests++;
        if (rd_data.size() != 8 || bad != 0 || lbad != 0) begin
            n_fail++; $display("FAIL rd_toggle_data: got %0d beats %0d bad data %0d bad last expected 8 0 0",
                rd_data.size(), bad, lbad);
        end
        n_tests++;
        if (c_done != c_last + 1 || done_cnt != 1 || {p_resp, p_err} !== 6'h0) begin
            n_fail++; $display("FAIL rd_toggle_status: got done-R %0d pulses %0d resp %b err %0d expected 1 1 00 0",
                c_done - c_last, done_cnt, p_resp, p_err);
        end
    endtask

    task automatic test_range();
        set_defaults();
        src.delete();
        src.push_back(64'h1); src.push_back(64'h2);
        do_cmd(1, 10'h3F8, 8'd1, 50);
        n_tests++;
        if (timed_out || saw_valid || w_data.size() != 0) begin
            n_fail++; $display("FAIL range_traffic: got to %0d axi_valid %0d wbeats %0d expected 0 0 0",
                timed_out, saw_valid, w_data.size());
        end
        n_tests++;
        if (c_done != c_acc + 1 || done_cnt != 1 || p_err !== 4'd1 || p_resp !== 2'b10) begin
            n_fail++; $display("FAIL range_status: got done-accept %0d pulses %0d err %0d resp %b expected 1 1 1 10",
                c_done - c_acc, done_cnt, p_err, p_resp);
        end
    endtask

    task automatic test_rlast_faults();
        int bad;
        for (int m = 1; m <= 2; m++) begin
            set_defaults();
            rlast_mode = m; early_idx = 1;
            do_cmd(0, 10'h080, 8'd3, 100);
            bad = 0;
            for (int i = 0; i < rd_data.size() && i < 4; i++) if (rd_data[i] !== ref_mem[16 + i]) bad++;
            n_tests++;
            if (timed_out || rd_data.size() != 4 || bad != 0 || done_cnt != 1) begin
                n_fail++; $display("FAIL rlast_mode%0d_beats: got to %0d beats %0d bad %0d pulses %0d expected 0 4 0 1",
                    m, timed_out, rd_data.size(), bad, done_cnt);
            end
            n_tests++;
            if (p_err !== 4'(m + 1) || p_resp !== 2'b00) begin
                n_fail++; $display("FAIL rlast_mode%0d_err: got err %0d resp %b expected %0d 00", m, p_err, p_resp, m + 1);
            end
        end
    endtask

    task automatic test_slverr();
        set_defaults();
        rresp_cfg[0] = 2'b10;
        do_cmd(0, 10'h000, 8'd0, 50);
        n_tests++;
        if (timed_out || rd_data.size() != 1 || done_cnt != 1 || p_resp !== 2'b10 || p_err !== 4'd5) begin
            n_fail++; $display("FAIL slverr: got to %0d beats %0d pulses %0d resp %b err %0d expected 0 1 1 10 5",
                timed_out, rd_data.size(), done_cnt, p_resp, p_err);
        end
    endtask

    task automatic test_timeout();
        int bad = 0;
        set_defaults();
        aw_stall_cfg = 10001;
        src.delete();
        src.push_back({$urandom, $urandom}); src.push_back({$urandom, $urandom});
        do_cmd(1, 10'h018, 8'd1, 10200);
        for (int i = 0; i < w_data.size() && i < 2; i++) if (w_data[i] !== src[i]) bad++;
        n_tests++;
        if (timed_out || aw_drop || n_aw != 1 || w_data.size() != 2 || bad != 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL timeout_flow: got to %0d awdrop %0d aw %0d beats %0d bad %0d pulses %0d expected 0 0 1 2 0 1",
                timed_out, aw_drop, n_aw, w_data.size(), bad, done_cnt);
        end
        n_tests++;
        if (!to_seen || p_to !== 1'b1 || p_err !== 4'd4 || p_resp !== 2'b00) begin
            n_fail++; $display("FAIL timeout_status: got seen %0d sticky %b err %0d resp %b expected 1 1 4 00",
                to_seen, p_to, p_err, p_resp);
        end
        ref_mem[3] = src[0]; ref_mem[4] = src[1];
    endtask

    task automatic test_random();
        bit wr, rng;
        logic [9:0] a;
        logic [7:0] l;
        int al, bad, lbad, beats;
        logic [1:0] er;
        logic [3:0] ee;
        for (int t = 0; t < 24; t++) begin
            set_defaults();
            wr = $urandom_range(1) == 1;
            a = 10'($urandom_range(1023));
            l = ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(15));
            aw_stall_cfg = $urandom_range(3);
            wr_rand = $urandom_range(1) == 1; wready_rand = $urandom_range(1) == 1;
            rvalid_rand = $urandom_range(1) == 1; rd_mode = $urandom_range(2);
            bresp_cfg = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
            for (int i = 0; i < 256; i++) rresp_cfg[i] = ($urandom_range(15) == 0) ? 2'($urandom_range(3)) : 2'b00;
            src.delete();
            for (int i = 0; i <= int'(l); i++) src.push_back({$urandom, $urandom});
            al = (int'(a) / 8) * 8;
            rng = al + (int'(l) + 1) * 8 > 1024;
            er = 2'b00;
            if (rng) er = 2'b10;
            else if (wr) er = bresp_cfg;
            else for (int i = 0; i <= int'(l); i++) if (rresp_cfg[i] > er) er = rresp_cfg[i];
            ee = rng ? 4'd1 : (er != 2'b00) ? 4'd5 : 4'd0;
            beats = rng ? 0 : int'(l) + 1;
            do_cmd(wr, a, l, 3000);
            bad = 0; lbad = 0;
            if (wr) begin
                for (int i = 0; i < w_data.size() && i < beats; i++) begin
                    if (w_data[i] !== src[i]) bad++;
                    if (w_last[i] != (i == beats - 1)) lbad++;
                end
            end else begin
                for (int i = 0; i < rd_data.size() && i < beats; i++) begin
                    if (rd_data[i] !== ref_mem[al / 8 + i]) bad++;
                    if (rd_last[i] != (i == beats - 1)) lbad++;
                end
            end
            n_tests++;
            if (timed_out || done_cnt != 1 || (wr ? w_data.size() : rd_data.size()) != beats || bad != 0 || lbad != 0) begin
                n_fail++; $display("FAIL rand%0d_data: wr %0d addr %h len %0d got to %0d pulses %0d beats %0d bad %0d badlast %0d expected 0 1 %0d 0 0",
                    t, wr, a, l, timed_out, done_cnt, wr ? w_data.size() : rd_data.size(), bad, lbad, beats);
            end
            n_tests++;
            if (p_resp !== er || p_err !== ee || p_to !== 1'b0 || p_ready !== 1'b1) begin
                n_fail++; $display("FAIL rand%0d_status: got resp %b err %0d to %b ready %b expected %b %0d 0 1",
                    t, p_resp, p_err, p_to, p_ready, er, ee);
            end
            n_tests++;
            if (!rng && (wr ? (o_awaddr !== 10'(al) || o_awlen !== l) : (o_araddr !== 10'(al) || o_arlen !== l))) begin
                n_fail++; $display("FAIL rand%0d_addr: got %h/%0d expected %h/%0d",
                    t, wr ? o_awaddr : o_araddr, wr ? o_awlen : o_arlen, 10'(al), l);
            end
            if (wr && !rng) for (int i = 0; i < beats; i++) ref_mem[al / 8 + i] = src[i];
        end
    endtask

    task automatic test_reset_mid();
        @(negedge ACLK);
        CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = 10'h20C; CMD_LEN = 8'd5; M_AXI_AWREADY = 0; WR_VALID = 1;
        @(negedge ACLK);
        CMD_VALID = 0;
        repeat (10005) @(negedge ACLK);
        #1;
        n_tests++;
        if ({M_AXI_AWVALID, STATUS_TIMEOUT, ERR_CODE, M_AXI_AWADDR, M_AXI_AWLEN} !== {1'b1, 1'b1, 4'd4, 10'h208, 8'd5}) begin
            n_fail++; $display("FAIL midreset_pre: got aw %b to %b err %0d addr %h len %0d expected 1 1 4 208 5",
                M_AXI_AWVALID, STATUS_TIMEOUT, ERR_CODE, M_AXI_AWADDR, M_AXI_AWLEN);
        end
        #2 ARESETN = 0;
        #1;
        n_tests++;
        if ({CMD_READY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, RD_VALID,
             WR_READY, DONE, STATUS_TIMEOUT, RESP, ERR_CODE} !== 16'h8000) begin
            n_fail++; $display("FAIL midreset_ctrl: got %h expected 8000", {CMD_READY, M_AXI_AWVALID, M_AXI_WVALID,
                M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, RD_VALID, WR_READY, DONE, STATUS_TIMEOUT, RESP, ERR_CODE});
        end
        n_tests++;
        if ({M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_ARADDR, M_AXI_ARLEN} !== 36'h0) begin
            n_fail++; $display("FAIL midreset_addr: got %h expected 0", {M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_ARADDR, M_AXI_ARLEN});
        end
        @(negedge ACLK);
        ARESETN = 1; WR_VALID = 0; M_AXI_AWREADY = 1;
        @(negedge ACLK);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = {$urandom, $urandom};
            ref_mem[i] = mem[i];
        end
        set_defaults();
        test_reset();
        test_write_basic();
        test_read_toggle();
        test_range();
        test_rlast_faults();
        test_slverr();
        test_timeout();
        test_random();
        test_reset_mid();
        test_write_basic();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_mram_dma_master.md
# axi_mram_dma_master

Single-outstanding AXI4 burst initiator that moves data between the accelerator's local streams and the 64-bit AXI MRAM slave. A command port requests one INCR read or write burst (1–256 beats). Write data is drawn from a valid/ready stream; read data is delivered to one. Response codes, protocol violations and stall timeouts are reported on a status port.

## Interface
- ADDR_WIDTH, 10: AXI byte-address width.
- DATA_WIDTH, 64: data width; beat size is DATA_WIDTH/8 bytes.
- TIMEOUT_CYCLE, 10000: stall cycles before STATUS_TIMEOUT asserts.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- CMD_VALID / CMD_READY  in/out  1/1  command handshake.
- CMD_WRITE  in  1  1 = write burst, 0 = read burst.
- CMD_ADDR  in  ADDR_WIDTH  start byte address. Low log2(DATA_WIDTH/8) bits are forced to 0.
- CMD_LEN  in  8  beats−1.
- WR_DATA / WR_VALID / WR_READY  in/in/out  DATA_WIDTH/1/1  write source stream.
- RD_DATA / RD_VALID / RD_LAST / RD_READY  out/out/out/in  DATA_WIDTH/1/1/1  read sink stream.
- M_AXI_AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID  out  ADDR_WIDTH/8/3/2/1; M_AXI_AWREADY in 1.
- M_AXI_WDATA, WLAST, WVALID  out  DATA_WIDTH/1/1; M_AXI_WREADY in 1.
- M_AXI_BRESP, BVALID  in  2/1; M_AXI_BREADY out 1.
- M_AXI_ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID  out  ADDR_WIDTH/8/3/2/1; M_AXI_ARREADY in 1.
- M_AXI_RDATA, RRESP, RLAST, RVALID  in  DATA_WIDTH/2/1/1; M_AXI_RREADY out 1.
- DONE  out  1  one-cycle pulse when a command completes.
- RESP  out  2  worst AXI response of the last command (priority 11 > 10 > 01 > 00).
- ERR_CODE  out  4  0 none, 1 range, 2 early RLAST, 3 missing RLAST, 4 timeout, 5 non-OKAY response.
- STATUS_TIMEOUT  out  1  sticky; cleared on the next command accept.

## Operation
- States: IDLE, AW, W, B, AR, R, FIN.
- CMD_READY = (state==IDLE).
- Range check at accept: if aligned CMD_ADDR + (CMD_LEN+1)·bytes exceeds 2^ADDR_WIDTH (width ADDR_WIDTH+9 arithmetic):
  - ERR_CODE=1, RESP=10, no AXI traffic.
  - Go to FIN.
- Otherwise latch addr/len, clear RESP, ERR_CODE and beat counter, then go to AW or AR.
- Constant outputs: AWSIZE/ARSIZE = log2(DATA_WIDTH/8) (3 by default); AWBURST/ARBURST = 01 (INCR).
- AW: AWVALID=1 until AWREADY, then go to W. W never starts before the AW handshake.
- W (combinational pass-through):
  - WVALID = WR_VALID; WDATA = WR_DATA; WR_READY = WREADY.
  - WLAST = (beat==len).
  - Each W handshake increments beat; the handshake with WLAST goes to B.
- B: BREADY=1. On BVALID, merge BRESP into RESP, then go to FIN.
- AR: ARVALID=1 until ARREADY, then go to R.
- R:
  - RD_VALID = RVALID; RD_DATA = RDATA; RD_LAST = (beat==len); RREADY = RD_READY.
  - Each R handshake merges RRESP into RESP and increments beat.
  - RLAST on beat<len: ERR_CODE=2; keep accepting until beat==len.
  - No RLAST on beat==len: ERR_CODE=3.
  - Handshake at beat==len goes to FIN.
- FIN: DONE=1 for one cycle. If RESP≠00 and ERR_CODE==0, set ERR_CODE=5. Return to IDLE.
- First recorded error code wins; later errors do not overwrite it.
- Timeout:
  - The counter increments while in AW/AR without ready, W with WVALID&&!WREADY, B without BVALID, or R without RVALID.
  - Any progress clears it.
  - At TIMEOUT_CYCLE, STATUS_TIMEOUT=1 and ERR_CODE=4 if still 0.
  - The FSM keeps waiting: valids are never withdrawn, per AXI rules.
- Reset mid-burst: all state returns to reset values immediately. The external slave is also reset.

## Timing
- Reset values:
  - All VALID/READY outputs 0 except CMD_READY=1.
  - AWADDR/ARADDR/AWLEN/ARLEN 0; AWSIZE/ARSIZE and AWBURST/ARBURST at their constants.
  - DONE 0, RESP 00, ERR_CODE 0, STATUS_TIMEOUT 0.
- Accept at edge N gives AWVALID/ARVALID=1 from edge N+1.
- AW/AR handshake at edge M gives WVALID/RREADY enabled from cycle M+1.
- The last B or R handshake at edge K gives DONE high in cycle K+1 and CMD_READY high in cycle K+2.
- A range-error command gives DONE one cycle after accept.
- Minimum write overhead is 4 cycles plus beats; read is 3 cycles plus beats.
- Back-to-back commands are permitted from the cycle CMD_READY returns.
- AW/AR outputs are registered; W/R stream paths are combinational.

## Test plan
- Write CMD_ADDR=0x040, CMD_LEN=3, slave always ready, BRESP=00:
  - AWADDR=0x040, AWLEN=3, AWSIZE=3.
  - Exactly 4 W beats with WLAST on the 4th.
  - DONE one cycle after B; RESP=00, ERR_CODE=0.
- Read CMD_ADDR=0x100, CMD_LEN=7, RRESP=00, RD_READY toggling 1/0:
  - 8 beats delivered in order; RD_LAST only on the 8th.
  - No beat lost while RREADY=0.
- Range: CMD_ADDR=0x3F8, CMD_LEN=1:
  - No AWVALID.
  - DONE one cycle after accept; ERR_CODE=1, RESP=10.
- Read CMD_LEN=3, slave asserts RLAST on beat 2:
  - ERR_CODE=2, all 4 beats still consumed.
  - Repeat with RLAST absent on beat 4: ERR_CODE=3.
- Read CMD_LEN=0, slave returns RRESP=10 (SLVERR):
  - RESP=10, ERR_CODE=5, DONE pulse.
- Write with AWREADY held 0 for 10001 cycles, TIMEOUT_CYCLE=10000:
  - STATUS_TIMEOUT=1, ERR_CODE=4, AWVALID stays high.
  - Completes normally once AWREADY rises.
  - Reset asserted mid-burst returns all outputs to reset values asynchronously.
